// File: rtl/sketch_pkg.sv
// Shared definitions for the sketch front-end blocks.
package sketch_pkg;

  localparam int EF_W   = 64;
  localparam int WORD_W = 32;

  // Placement of the key (e) and the value (f) inside one element.
  localparam int E_MSB  = 63;
  localparam int F_LSB  = 0;

  // Pairing state: waiting for a key word, or holding a key and waiting for its value.
  typedef enum logic {
    WAIT_E = 1'b0,
    WAIT_F = 1'b1
  } pair_state_t;

endpackage

// File: rtl/ef_sync_fifo.sv
// Single-clock FIFO with registered read data and an extra pointer bit
// to tell full from empty. A write on a full FIFO is accepted only when
// a read frees a slot in the same cycle; a read on an empty FIFO is ignored.
module ef_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int PTR   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PTR:0]     count
);

  localparam int DEPTH = 1 << PTR;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR:0]     wr_ptr;
  logic [PTR:0]     rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR] != rd_ptr[PTR]) &&
                 (wr_ptr[PTR-1:0] == rd_ptr[PTR-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  // Storage array: written on accepted pushes only.
  // NOTE: the array has no reset; contents are only observed after a write
  // has made them valid, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr[PTR-1:0]] <= din;
    end
  end

  // Read and write pointers, wrapping modulo 2*DEPTH.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Registered read data; holds its value between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (rd_ok) begin
      dout <= mem[rd_ptr[PTR-1:0]];
    end
  end

endmodule

// File: rtl/ef_stream_packer.sv
// Packs a 32-bit word stream into {e, f} pairs, buffers them, and issues
// them to the sketch as paced single-cycle valid pulses.
module ef_stream_packer
  import sketch_pkg::*;
#(
  parameter int          FIFO_PTR = 4,
  parameter int unsigned GAP      = 0,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              en,
  output logic [EF_W-1:0]   e_f,
  output logic              valid,
  output logic [CNT_W-1:0]  pair_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [FIFO_PTR:0] DEPTH_C = (FIFO_PTR + 1)'(1 << FIFO_PTR);

  pair_state_t       state_q;
  pair_state_t       next_state;
  logic [WORD_W-1:0] e_hold;
  logic [GAP_W-1:0]  gap_q;

  logic              beat;
  logic              e_load;
  logic              pair_wr;
  logic              orphan;
  logic              rd_fire;

  logic [EF_W-1:0]   fifo_din;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_PTR:0] fifo_count;
  logic [FIFO_PTR:0] count_after_rd;

  // Read side: drain one element when enabled, non-empty and pacing allows.
  assign rd_fire = en && !fifo_empty && (gap_q == '0);

  // Occupancy as seen by the incoming f word, crediting the read this cycle.
  assign count_after_rd = fifo_count - (FIFO_PTR + 1)'(rd_fire);

  // A key can always be latched; a value needs a free slot.
  assign in_ready = rst_n && ((state_q == WAIT_E) || (count_after_rd < DEPTH_C));
  assign beat     = in_valid && in_ready;

  assign fifo_din[E_MSB -: WORD_W] = e_hold;
  assign fifo_din[F_LSB +: WORD_W] = in_data;

  // Pairing FSM next-state and per-beat actions.
  // NOTE: every signal driven here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state = state_q;
    e_load     = 1'b0;
    pair_wr    = 1'b0;
    orphan     = 1'b0;
    if (beat) begin
      case (state_q)
        WAIT_E: begin
          if (in_last) begin
            orphan = 1'b1;
          end else begin
            e_load     = 1'b1;
            next_state = WAIT_F;
          end
        end
        WAIT_F: begin
          pair_wr    = 1'b1;
          next_state = WAIT_E;
        end
        default: next_state = WAIT_E;
      endcase
    end
  end

  // Pairing FSM state and the held key word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WAIT_E;
      e_hold  <= '0;
    end else begin
      state_q <= next_state;
      if (e_load) e_hold <= in_data;
    end
  end

  ef_sync_fifo #(
    .WIDTH (EF_W),
    .PTR   (FIFO_PTR)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (pair_wr && (!fifo_full || rd_fire)),
    .rd_en (rd_fire),
    .din   (fifo_din),
    .dout  (e_f),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Output qualifier: one pulse per read, aligned with the registered data.
  always_ff @(posedge clk) begin
    if (!rst_n) valid <= 1'b0;
    else        valid <= rd_fire;
  end

  // Pacing counter: loads GAP on a read, then counts idle cycles down to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else if (rd_fire) begin
      gap_q <= GAP_W'(GAP);
    end else if (gap_q != '0) begin
      gap_q <= gap_q - 1'b1;
    end
  end

  // Saturating statistics: pairs emitted and orphan keys dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pair_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (rd_fire && (pair_cnt != '1)) pair_cnt <= pair_cnt + 1'b1;
      if (orphan  && (err_cnt  != '1)) err_cnt  <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ef_stream_packer.sv
// Bench for ef_stream_packer: a small-FIFO instance (FIFO_PTR=2, GAP=0)
// and a paced instance (GAP=3) share the input stream and reset.
module tb_ef_stream_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        en_a = 1'b0;
  logic        en_b = 1'b0;

  logic        in_ready_a, in_ready_b;
  logic [63:0] e_f_a, e_f_b;
  logic        valid_a, valid_b;
  logic [31:0] pair_cnt_a, pair_cnt_b, err_cnt_a, err_cnt_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic        mon_on = 1'b0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ef_stream_packer #(.FIFO_PTR(2), .GAP(0), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_a), .en(en_a), .e_f(e_f_a),
    .valid(valid_a), .pair_cnt(pair_cnt_a), .err_cnt(err_cnt_a)
  );

  ef_stream_packer #(.FIFO_PTR(4), .GAP(3), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_b), .en(en_b), .e_f(e_f_b),
    .valid(valid_b), .pair_cnt(pair_cnt_b), .err_cnt(err_cnt_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input int e, input int f);
    logic [31:0] ew, fw;
    ew = e;
    fw = f;
    return {ew, fw};
  endfunction

  // Scoreboard for dut_a output stream.
  always @(negedge clk) begin
    if (mon_on && rst_n && valid_a) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: e_f=%h expected no output", e_f_a);
      end else begin
        check("stream_order", e_f_a, exp_q.pop_front());
      end
    end
  end

  // Present one word at a negedge and hold it until dut_a accepts it.
  task automatic send_word(input logic [31:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    while (!in_ready_a && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready_a) check("send_ready_timeout", in_ready_a, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    #1;
    check("ready_in_reset_a", in_ready_a, 1'b0);
    check("ready_in_reset_b", in_ready_b, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", in_ready_a, 1'b1);
  endtask

  typedef struct {
    logic        v;
    logic        last;
    logic [31:0] data;
    logic        en;
    logic        exp_ready;
    logic        exp_valid;
    logic [63:0] exp_ef;
    logic [31:0] exp_pairs;
    logic [31:0] exp_errs;
  } vec_t;

  vec_t vecs [9];

  int pulse_n;
  int last_cyc;

  initial begin
    // Basic pair, then orphan followed by a normal pair.
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0011, 1'b1, 1'b1, 1'b0, 64'h0, 32'd0, 32'd0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0022, 1'b1, 1'b1, 1'b0, 64'h0, 32'd0, 32'd0};
    vecs[2] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 64'h0000_0011_0000_0022, 32'd1, 32'd0};
    vecs[3] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 64'h0000_0011_0000_0022, 32'd1, 32'd0};
    vecs[4] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 64'h0000_0011_0000_0022, 32'd1, 32'd1};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_000A, 1'b1, 1'b1, 1'b0, 64'h0000_0011_0000_0022, 32'd1, 32'd1};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_000B, 1'b1, 1'b1, 1'b0, 64'h0000_0011_0000_0022, 32'd1, 32'd1};
    vecs[7] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 64'h0000_000A_0000_000B, 32'd2, 32'd1};
    vecs[8] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 64'h0000_000A_0000_000B, 32'd2, 32'd1};

    do_reset();
    check("reset_ef", e_f_a, 64'h0);
    check("reset_valid", valid_a, 1'b0);
    check("reset_pair_cnt", pair_cnt_a, 32'd0);
    check("reset_err_cnt", err_cnt_a, 32'd0);

    // Table-driven cycle vectors.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      in_valid = vecs[i].v;
      in_last  = vecs[i].last;
      in_data  = vecs[i].data;
      en_a     = vecs[i].en;
      #1;
      check($sformatf("vec%0d_ready", i), in_ready_a, vecs[i].exp_ready);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), valid_a, vecs[i].exp_valid);
      check($sformatf("vec%0d_ef", i), e_f_a, vecs[i].exp_ef);
      check($sformatf("vec%0d_pairs", i), pair_cnt_a, vecs[i].exp_pairs);
      check($sformatf("vec%0d_errs", i), err_cnt_a, vecs[i].exp_errs);
    end
    in_valid = 1'b0;
    en_a = 1'b0;

    // Full FIFO with en low, then drain with a write landing on the full FIFO.
    do_reset();
    mon_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_word(32'h100 + i, 1'b0);
      send_word(32'h200 + i, 1'b0);
    end
    send_word(32'h104, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h204;
    #1;
    check("full_refuse", in_ready_a, 1'b0);
    @(negedge clk);
    #1;
    check("full_refuse_hold", in_ready_a, 1'b0);
    check("full_no_valid", valid_a, 1'b0);
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(32'h100 + i, 32'h200 + i));
    en_a = 1'b1;
    #1;
    check("rw_at_full_ready", in_ready_a, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("full_drained", exp_q.size(), 0);
    check("full_pair_cnt", pair_cnt_a, 32'd5);

    // Reset mid-stream: two pairs queued and a key held.
    en_a = 1'b0;
    send_word(32'h0000_0BAD, 1'b1);
    send_word(32'h500, 1'b0);
    send_word(32'h600, 1'b0);
    send_word(32'h501, 1'b0);
    send_word(32'h601, 1'b0);
    send_word(32'h77, 1'b0);
    check("pre_reset_err_cnt", err_cnt_a, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_ready", in_ready_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    en_a = 1'b1;
    #1;
    check("mid_release_ready", in_ready_a, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_valid%0d", i), valid_a, 1'b0);
    end
    check("post_reset_pair_cnt", pair_cnt_a, 32'd0);
    check("post_reset_err_cnt", err_cnt_a, 32'd0);
    exp_q.push_back(64'h0000_0001_0000_0002);
    @(negedge clk);
    send_word(32'h1, 1'b0);
    send_word(32'h2, 1'b0);
    repeat (6) @(negedge clk);
    check("post_reset_drained", exp_q.size(), 0);
    check("post_reset_pairs", pair_cnt_a, 32'd1);

    // Pacing on the GAP=3 instance with four pairs preloaded.
    mon_on = 1'b0;
    en_a = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_word(32'h300 + i, 1'b0);
      send_word(32'h400 + i, 1'b0);
    end
    check("pace_preload_idle", valid_b, 1'b0);
    en_b = 1'b1;
    pulse_n = 0;
    last_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_b) begin
        if (pulse_n < 4)
          check($sformatf("pace_ef%0d", pulse_n), e_f_b, mk(32'h300 + pulse_n, 32'h400 + pulse_n));
        if (pulse_n > 0)
          check($sformatf("pace_spacing%0d", pulse_n), cyc - last_cyc, 4);
        last_cyc = cyc;
        pulse_n++;
      end
    end
    check("pace_pulses", pulse_n, 4);
    check("pace_pair_cnt", pair_cnt_b, 32'd4);
    check("pace_err_cnt", err_cnt_b, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
